// File: rtl/div_pkg.sv
// Shared types and helpers for the shift-subtract sequential divider.
// Helpers work on MAX_W-bit vectors with a runtime width so any NUM_BITS <= MAX_W can use them.
package div_pkg;

   localparam int unsigned MAX_W = 64;

   localparam logic [MAX_W-1:0] DBZ_QUOTIENT = '1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDiv  = 2'd1,
      StFix  = 2'd2
   } state_e;

   // Negation confined to the low w bits; bits above w are returned as zero.
   function automatic logic [MAX_W-1:0] twos_complement(input logic [MAX_W-1:0] x,
                                                        input int unsigned w);
      logic [MAX_W-1:0] mask;
      mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      return (~x + MAX_W'(1)) & mask;
   endfunction

   // |MIN| comes out as 2^(w-1), which is the intended unsigned magnitude.
   function automatic logic [MAX_W-1:0] abs(input logic [MAX_W-1:0] x, input int unsigned w);
      return x[w-1] ? twos_complement(x, w) : x;
   endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restoring_step #(
   parameter int unsigned NUM_BITS = 32
) (
   input  logic [NUM_BITS-1:0] rem,
   input  logic                bit_in,
   input  logic [NUM_BITS-1:0] divisor,
   output logic [NUM_BITS-1:0] rem_next,
   output logic                q_bit
);

   logic [NUM_BITS:0] shifted;
   logic [NUM_BITS:0] trial;

   // Full N+1-bit shift keeps the remainder MSB, which matters for divisors above 2^(N-1).
   always_comb begin
      shifted  = {rem, bit_in};
      trial    = shifted - {1'b0, divisor};
      q_bit    = ~trial[NUM_BITS];
      rem_next = q_bit ? trial[NUM_BITS-1:0] : shifted[NUM_BITS-1:0];
   end

endmodule

// File: rtl/shift_sub_seq_divider.sv
// Radix-2 restoring sequential divider, one quotient bit per clock, signed or unsigned per op.
// Magnitudes are divided unsigned; signs are reapplied in a single fix-up cycle.
module shift_sub_seq_divider
   import div_pkg::*;
#(
   parameter int unsigned NUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sign_op,
   input  logic [NUM_BITS-1:0] dividend,
   input  logic [NUM_BITS-1:0] divisor,
   output logic                busy,
   output logic                done,
   output logic [NUM_BITS-1:0] quotient,
   output logic [NUM_BITS-1:0] remainder,
   output logic                div_by_zero
);

   localparam int unsigned CntW = $clog2(NUM_BITS);

   state_e              state_q, state_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [NUM_BITS-1:0] q_sr_q, q_sr_d;
   logic [NUM_BITS-1:0] rem_q, rem_d;
   logic [NUM_BITS-1:0] dvs_q, dvs_d;
   logic [NUM_BITS-1:0] dvd_q, dvd_d;
   logic [NUM_BITS-1:0] quotient_q, quotient_d;
   logic [NUM_BITS-1:0] remainder_q, remainder_d;
   logic                dvd_neg_q, dvd_neg_d;
   logic                dvs_neg_q, dvs_neg_d;
   logic                dbz_q, dbz_d;
   logic                div_by_zero_q, div_by_zero_d;
   logic                done_q, done_d;

   logic [NUM_BITS-1:0] step_rem;
   logic                step_q;

   div_restoring_step #(
      .NUM_BITS (NUM_BITS)
   ) u_step (
      .rem      (rem_q),
      .bit_in   (q_sr_q[NUM_BITS-1]),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      q_sr_d        = q_sr_q;
      rem_d         = rem_q;
      dvs_d         = dvs_q;
      dvd_d         = dvd_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      dvd_neg_d     = dvd_neg_q;
      dvs_neg_d     = dvs_neg_q;
      dbz_d         = dbz_q;
      div_by_zero_d = div_by_zero_q;
      done_d        = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               dvd_d     = dividend;
               dvd_neg_d = sign_op & dividend[NUM_BITS-1];
               dvs_neg_d = sign_op & divisor[NUM_BITS-1];
               q_sr_d    = sign_op ? NUM_BITS'(abs(MAX_W'(dividend), NUM_BITS)) : dividend;
               dvs_d     = sign_op ? NUM_BITS'(abs(MAX_W'(divisor), NUM_BITS)) : divisor;
               rem_d     = '0;
               count_d   = '0;
               dbz_d     = (divisor == '0);
               state_d   = (divisor == '0) ? StFix : StDiv;
            end
         end
         StDiv: begin
            rem_d   = step_rem;
            q_sr_d  = {q_sr_q[NUM_BITS-2:0], step_q};
            count_d = count_q + CntW'(1);
            if (count_q == CntW'(NUM_BITS - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (dbz_q) begin
               quotient_d    = DBZ_QUOTIENT[NUM_BITS-1:0];
               remainder_d   = dvd_q;
               div_by_zero_d = 1'b1;
            end else begin
               quotient_d    = (dvd_neg_q ^ dvs_neg_q) ?
                               NUM_BITS'(twos_complement(MAX_W'(q_sr_q), NUM_BITS)) : q_sr_q;
               remainder_d   = dvd_neg_q ?
                               NUM_BITS'(twos_complement(MAX_W'(rem_q), NUM_BITS)) : rem_q;
               div_by_zero_d = 1'b0;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         count_q       <= '0;
         q_sr_q        <= '0;
         rem_q         <= '0;
         dvs_q         <= '0;
         dvd_q         <= '0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         dvd_neg_q     <= 1'b0;
         dvs_neg_q     <= 1'b0;
         dbz_q         <= 1'b0;
         div_by_zero_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         q_sr_q        <= q_sr_d;
         rem_q         <= rem_d;
         dvs_q         <= dvs_d;
         dvd_q         <= dvd_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         dvd_neg_q     <= dvd_neg_d;
         dvs_neg_q     <= dvs_neg_d;
         dbz_q         <= dbz_d;
         div_by_zero_q <= div_by_zero_d;
         done_q        <= done_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule
